// File: rtl/serial_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_sync
//  Purpose  : Bit-level frame aligner for the 64-bit deserializer output.
//             Hunts for a 16-bit sync header at any of 64 bit offsets and
//             confirms it over VERIFY_N words. Once locked, it emits aligned
//             64-bit frames with a header-error flag, and drops back to
//             hunting after LOSS_N consecutive bad headers.
//  Options  : define SERIAL_FRAME_SYNC_STATS_EN to add the HERR_CNT and
//             LOSS_CNT statistics outputs.
//  Revision : 1.0  initial release
// ============================================================================
module serial_frame_sync #(
  parameter logic [15:0] SYNC_PAT = 16'hA5C3,
  parameter int unsigned VERIFY_N = 4,
  parameter int unsigned LOSS_N   = 3
) (
  input  logic        CLKS,
  input  logic        RSTS,
  input  logic [63:0] DIN,
  input  logic        DIN_VLD,
  input  logic        RESYNC,
  output logic [63:0] DOUT,
  output logic        DOUT_VLD,
  output logic        DOUT_HERR,
  output logic        LOCK,
  output logic [5:0]  OFFSET
`ifdef SERIAL_FRAME_SYNC_STATS_EN
  ,
  output logic [15:0] HERR_CNT,
  output logic [7:0]  LOSS_CNT
`endif
);

  // Counter limits narrowed to the 4-bit counter width (both limited to 1..15).
  localparam logic [3:0] VERIFY_LIM = VERIFY_N[3:0];
  localparam logic [3:0] LOSS_LIM   = LOSS_N[3:0];

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic [63:0]   prev;
  logic [3:0]    vcnt;
  logic [3:0]    mcnt;

  logic [127:0]  cat;
  logic [63:0]   hit;
  logic          found;
  logic [5:0]    found_k;
  logic [63:0]   cand;
  logic          cur_match;
  logic          locked_strobe;

  // Two-word window: previous word followed by the current one.
  assign cat = {prev, DIN};

  // Header comparators for every candidate offset, evaluated in parallel.
  for (genvar k = 0; k < 64; k++) begin : g_hdr
    assign hit[k] = (cat[127-k -: 16] == SYNC_PAT);
  end

  assign found = |hit;

  // Lowest matching offset wins when several offsets carry the pattern.
  always_comb begin
    found_k = 6'd0;
    for (int k = 63; k >= 0; k--) begin
      if (hit[k]) begin
        found_k = 6'(k);
      end
    end
  end

  // Candidate frame at the current offset and its header check.
  assign cand          = cat[7'd127 - {1'b0, OFFSET} -: 64];
  assign cur_match     = (cand[63:48] == SYNC_PAT);
  assign locked_strobe = DIN_VLD && !RESYNC && (state == ST_LOCKED);

  // Alignment state machine with registered frame outputs.
  always_ff @(posedge CLKS) begin
    if (RSTS) begin
      state     <= ST_HUNT;
      prev      <= '0;
      vcnt      <= '0;
      mcnt      <= '0;
      DOUT      <= '0;
      DOUT_VLD  <= 1'b0;
      DOUT_HERR <= 1'b0;
      LOCK      <= 1'b0;
      OFFSET    <= '0;
    end else begin
      DOUT_VLD  <= 1'b0;
      DOUT_HERR <= 1'b0;

      // The window history advances on every strobe, even during RESYNC.
      if (DIN_VLD) begin
        prev <= DIN;
      end

      if (RESYNC) begin
        // Forced re-hunt; the offset is kept until a new find replaces it.
        state <= ST_HUNT;
        vcnt  <= '0;
        mcnt  <= '0;
        LOCK  <= 1'b0;
      end else if (DIN_VLD) begin
        case (state)
          ST_HUNT: begin
            if (found) begin
              OFFSET <= found_k;
              vcnt   <= 4'd1;
              if (VERIFY_LIM == 4'd1) begin
                state <= ST_LOCKED;
                LOCK  <= 1'b1;
                mcnt  <= '0;
              end else begin
                state <= ST_VERIFY;
              end
            end
          end

          ST_VERIFY: begin
            if (cur_match) begin
              vcnt <= vcnt + 4'd1;
              if (vcnt + 4'd1 == VERIFY_LIM) begin
                state <= ST_LOCKED;
                LOCK  <= 1'b1;
                mcnt  <= '0;
              end
            end else begin
              // The failing word is not searched again; hunting resumes next strobe.
              state <= ST_HUNT;
              vcnt  <= '0;
            end
          end

          ST_LOCKED: begin
            DOUT      <= cand;
            DOUT_VLD  <= 1'b1;
            DOUT_HERR <= !cur_match;
            if (cur_match) begin
              mcnt <= '0;
            end else if (mcnt + 4'd1 == LOSS_LIM) begin
              state <= ST_HUNT;
              LOCK  <= 1'b0;
              vcnt  <= '0;
              mcnt  <= '0;
            end else begin
              mcnt <= mcnt + 4'd1;
            end
          end

          default: begin
            state <= ST_HUNT;
            vcnt  <= '0;
            mcnt  <= '0;
            LOCK  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SERIAL_FRAME_SYNC_STATS_EN
  logic herr_evt;
  logic loss_evt;

  assign herr_evt = locked_strobe && !cur_match;
  assign loss_evt = herr_evt && (mcnt + 4'd1 == LOSS_LIM);

  // Saturating event counters; only reset clears them.
  always_ff @(posedge CLKS) begin
    if (RSTS) begin
      HERR_CNT <= '0;
      LOSS_CNT <= '0;
    end else begin
      if (herr_evt && (HERR_CNT != 16'hFFFF)) begin
        HERR_CNT <= HERR_CNT + 16'd1;
      end
      if (loss_evt && (LOSS_CNT != 8'hFF)) begin
        LOSS_CNT <= LOSS_CNT + 8'd1;
      end
    end
  end
`else
  // Keeps the locked-strobe term referenced when statistics are absent.
  logic unused_ok;
  assign unused_ok = locked_strobe;
`endif

endmodule
`default_nettype wire
